div_share_arb: RTL and testbench
================================

DIV_SHARE_ARB -- requirements
Module: div_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the divider.
REQ-002 Parameter W, default 8: operand and result width.
REQ-003 Parameter DIV_LAT, default 1, range 1..15: cycles the divider needs for div_q/div_r to settle after div_a/div_b change.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NREQ  per-requester request, level, held until gnt.
REQ-007 a_in  input  NREQ*W  packed dividends; requester i uses bits [i*W +: W].
REQ-008 b_in  input  NREQ*W  packed divisors; same packing as a_in.
REQ-009 gnt  output  NREQ  one-hot, one-cycle pulse: the operands of the granted requester are captured.
REQ-010 done  output  NREQ  one-hot, one-cycle pulse: q_out/r_out/dz are valid for that requester.
REQ-011 q_out  output  W  registered quotient.
REQ-012 r_out  output  W  registered remainder.
REQ-013 dz  output  1  divide-by-zero flag, valid with done.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 div_a  output  W  registered dividend driven to the shared combinational divider.
REQ-016 div_b  output  W  registered divisor driven to the shared combinational divider.
REQ-017 div_q  input  W  divider quotient.
REQ-018 div_r  input  W  divider remainder.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020 In IDLE with any req bit set, the block SHALL select the winner by round-robin, searching from ptr upward with wrap-around modulo NREQ.
REQ-021 On that cycle it SHALL pulse gnt[winner], load div_a/div_b from the winner's slices, store the winner index in owner, load lat_cnt with DIV_LAT-1, and go to EXEC.
REQ-022 In IDLE with req all zero, the block SHALL hold its state and keep gnt and done at zero.
REQ-023 In EXEC the block SHALL decrement lat_cnt each cycle while lat_cnt is nonzero; when lat_cnt is zero it SHALL capture results and go to RESP.
REQ-024 Result capture with div_b nonzero: q_out<=div_q, r_out<=div_r, dz<=0.
REQ-025 Result capture with div_b zero: q_out<=all ones, r_out<=div_a, dz<=1; div_q/div_r are ignored.
REQ-026 In RESP the block SHALL pulse done[owner], set ptr<=(owner+1) mod NREQ, and return to IDLE.
REQ-027 The latency from the gnt cycle to the done cycle SHALL be DIV_LAT+1 cycles.
REQ-028 Issue-to-issue spacing SHALL be DIV_LAT+2 cycles; a new grant is possible in the cycle after RESP.
REQ-029 The block SHALL issue no grant while in EXEC or RESP; req bits asserted during those states wait.
REQ-030 div_a and div_b SHALL be stable from the gnt cycle through the capture cycle.
REQ-031 q_out, r_out and dz SHALL hold their values until the next capture.
REQ-032 Deasserting a req before its gnt SHALL cancel that request with no side effect.
REQ-033 Changes to a_in/b_in after gnt SHALL not affect the operation in flight.
REQ-034 gnt and done SHALL never have more than one bit set, and SHALL never be asserted in the same cycle.

Reset
REQ-035 When rst is high at a clock edge, the block SHALL enter IDLE with ptr=0, owner=0, lat_cnt=0, gnt=0, done=0, q_out=0, r_out=0, dz=0, div_a=0, div_b=0 and busy=0.
REQ-036 Reset asserted mid-operation SHALL abort the operation without any done pulse; the requester must re-request.
REQ-037 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-038 DIV_LAT=1, req=0001, a0=200, b0=7 -> gnt=0001 at cycle t, done=0001 at t+2, q_out=28, r_out=4, dz=0.
REQ-039 req=1111 held continuously after reset -> grant order 0,1,2,3,0, each grant spaced DIV_LAT+2 cycles apart.
REQ-040 req=0100, a2=55, b2=0 -> done=0100, q_out=255, r_out=55, dz=1.
REQ-041 DIV_LAT=3, requester 1 granted with a1=9, b1=2, then rst asserted 2 cycles after gnt -> no done pulse; busy=0 and q_out=0 on the next cycle; ptr=0.
REQ-042 Sweep all 65536 (a,b) pairs through requester 3 against the reference divider model -> q_out/r_out match for every b nonzero; dz=1 exactly when b=0.
REQ-043 req=0010 asserted during EXEC of requester 0, then dropped before the RESP cycle -> no gnt to requester 1; block returns to IDLE.

Source files
------------

// File: rtl/div_share_arb.sv
// Round-robin arbiter that time-shares one external combinational divider
// among NREQ requesters, with a fixed settle time of DIV_LAT cycles.
module div_share_arb #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int DIV_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [W-1:0]      q_out,
   output logic [W-1:0]      r_out,
   output logic              dz,
   output logic              busy,
   output logic [W-1:0]      div_a,
   output logic [W-1:0]      div_b,
   input  logic [W-1:0]      div_q,
   input  logic [W-1:0]      div_r
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state;
   state_t        state_n;
   logic [IW-1:0] ptr;
   logic [IW-1:0] owner;
   logic [IW-1:0] win;
   logic [3:0]    lat_cnt;
   logic          found;
   logic          load;
   logic          capture;

   // first requester at or above ptr, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            win   = IW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      gnt     = '0;
      done    = '0;
      load    = 1'b0;
      capture = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               gnt[win] = 1'b1;
               load     = 1'b1;
               state_n  = EXEC;
            end
         end
         EXEC: begin
            if (lat_cnt == '0) begin
               capture = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            done[owner] = 1'b1;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // a reset edge aborts everything, so nothing may be announced either
      if (rst) begin
         gnt     = '0;
         done    = '0;
         load    = 1'b0;
         capture = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= '0;
         owner   <= '0;
         lat_cnt <= '0;
         div_a   <= '0;
         div_b   <= '0;
         q_out   <= '0;
         r_out   <= '0;
         dz      <= 1'b0;
      end else begin
         if (load) begin
            div_a   <= a_in[int'(win)*W +: W];
            div_b   <= b_in[int'(win)*W +: W];
            owner   <= win;
            lat_cnt <= 4'(DIV_LAT - 1);
         end else if (state == EXEC && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 4'd1;
         end
         if (capture) begin
            if (div_b != '0) begin
               q_out <= div_q;
               r_out <= div_r;
               dz    <= 1'b0;
            end else begin
               q_out <= '1;
               r_out <= div_a;
               dz    <= 1'b1;
            end
         end
         if (state == RESP) begin
            if (owner == IW'(NREQ - 1)) ptr <= '0;
            else                        ptr <= owner + 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_share_arb.sv
// Bench for div_share_arb: two instances (DIV_LAT 1 and 3), each fed by a
// divider model that returns corrupted values until its inputs have settled.
module tb_div_share_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] a_in;
   logic [31:0] b_in;

   logic [3:0] gnt1, done1, gnt3, done3;
   logic [7:0] q1, r1, da1, db1, dq1, dr1;
   logic [7:0] q3, r3, da3, db3, dq3, dr3;
   logic       dz1, busy1, dz3, busy3;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   div_share_arb #(.NREQ(4), .W(8), .DIV_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt1), .done(done1), .q_out(q1), .r_out(r1), .dz(dz1),
      .busy(busy1), .div_a(da1), .div_b(db1), .div_q(dq1), .div_r(dr1)
   );

   div_share_arb #(.NREQ(4), .W(8), .DIV_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt3), .done(done3), .q_out(q3), .r_out(r3), .dz(dz3),
      .busy(busy3), .div_a(da3), .div_b(db3), .div_q(dq3), .div_r(dr3)
   );

   // divider models: output is wrong until operands are stable DIV_LAT cycles
   int          age1 = 0;
   int          age3 = 0;
   logic [15:0] last1 = '1;
   logic [15:0] last3 = '1;

   always @(negedge clk) begin
      if ({da1, db1} !== last1) begin
         last1 = {da1, db1};
         age1  = 1;
      end else if (age1 < 100) age1++;
      if ({da3, db3} !== last3) begin
         last3 = {da3, db3};
         age3  = 1;
      end else if (age3 < 100) age3++;
   end

   always_comb begin
      dq1 = 8'h00;
      dr1 = 8'h00;
      if (db1 != 0) begin
         dq1 = (age1 >= 1) ? da1 / db1 : (da1 / db1) ^ 8'h5A;
         dr1 = (age1 >= 1) ? da1 % db1 : (da1 % db1) ^ 8'hC3;
      end
   end

   always_comb begin
      dq3 = 8'h00;
      dr3 = 8'h00;
      if (db3 != 0) begin
         dq3 = (age3 >= 3) ? da3 / db3 : (da3 / db3) ^ 8'h5A;
         dr3 = (age3 >= 3) ? da3 % db3 : (da3 % db3) ^ 8'hC3;
      end
   end

   // selected instance for run_op
   logic       use3;
   logic [3:0] gnt_s, done_s;
   logic [7:0] q_s, r_s;
   logic       dz_s, busy_s;

   always_comb begin
      gnt_s  = use3 ? gnt3  : gnt1;
      done_s = use3 ? done3 : done1;
      q_s    = use3 ? q3    : q1;
      r_s    = use3 ? r3    : r1;
      dz_s   = use3 ? dz3   : dz1;
      busy_s = use3 ? busy3 : busy1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // gnt/done one-hot and never together, on both instances
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("excl1", {31'd0, $onehot0(gnt1) && $onehot0(done1) &&
                       !(|gnt1 && |done1)}, 32'd1);
         chk("excl3", {31'd0, $onehot0(gnt3) && $onehot0(done3) &&
                       !(|gnt3 && |done3)}, 32'd1);
      end
   end

   function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output logic z);
      if (b == 0) begin
         q = 8'hFF;
         r = a;
         z = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   function automatic int rr_pick(input logic [3:0] mask, input int p);
      for (int k = 0; k < 4; k++)
         if (mask[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b);
      int         lat;
      int         k;
      logic [7:0] eq, er;
      logic       ez;
      lat = use3 ? 3 : 1;
      ref_div(a, b, eq, er, ez);
      req[i]          = 1'b1;
      a_in[i*8 +: 8] = a;
      b_in[i*8 +: 8] = b;
      k = 0;
      @(negedge clk);
      while (gnt_s == 0 && k < 20) begin
         k++;
         @(negedge clk);
      end
      chk("gnt", gnt_s, 32'd1 << i);
      step();
      req[i]          = 1'b0;
      a_in[i*8 +: 8] = 8'($urandom);
      b_in[i*8 +: 8] = 8'($urandom);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         chk("early_done", done_s, 0);
         chk("busy_exec", busy_s, 1);
      end
      @(negedge clk);
      chk("done", done_s, 32'd1 << i);
      chk("q", q_s, eq);
      chk("r", r_s, er);
      chk("dz", dz_s, ez);
      step();
   endtask

   int         gidx[$];
   int         gcyc[$];
   int         nd;
   int         p;
   int         w;
   int         k;
   logic [7:0] eq, er, ta, tb;
   logic       ez;
   logic [7:0] bnd_a [7];
   logic [7:0] bnd_b [7];

   initial begin
      use3 = 1'b0;
      req  = '0;
      a_in = '0;
      b_in = '0;
      rst  = 1'b1;

      // reset has priority over a pending request
      req = 4'hF;
      @(negedge clk);
      chk("rst_gnt", gnt1, 0);
      step();
      step();
      req = '0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_q", q1, 0);
      chk("rst_r", r1, 0);
      chk("rst_dz", dz1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_div_a", da1, 0);
      chk("rst_div_b", db1, 0);
      chk("rst_gnt0", gnt1, 0);
      chk("rst_done0", done1, 0);
      step();

      // 200 / 7 through requester 0
      run_op(0, 8'd200, 8'd7);
      chk("q_200_7", q1, 8'd28);
      chk("r_200_7", r1, 8'd4);

      // idle with no requests: nothing moves, results hold
      repeat (3) begin
         @(negedge clk);
         chk("idle_gnt", gnt1, 0);
         chk("idle_done", done1, 0);
         chk("idle_busy", busy1, 0);
         chk("idle_hold_q", q1, 8'd28);
      end
      step();

      // all four requesting after reset: round-robin order and spacing
      do_reset();
      a_in = $urandom;
      b_in = $urandom;
      req  = 4'hF;
      nd   = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int bi = 0; bi < 4; bi++) begin
            if (gnt1[bi]) begin
               gidx.push_back(bi);
               gcyc.push_back(c);
            end
         end
         if (done1 != 0 && nd < gidx.size()) begin
            w = gidx[nd];
            nd++;
            ta = a_in[w*8 +: 8];
            tb = b_in[w*8 +: 8];
            ref_div(ta, tb, eq, er, ez);
            chk("rr_done", done1, 32'd1 << w);
            chk("rr_q", q1, eq);
            chk("rr_r", r1, er);
            chk("rr_dz", dz1, ez);
         end
      end
      step();
      req = '0;
      chk("rr_count", gidx.size() >= 5, 1);
      if (gidx.size() >= 5) begin
         chk("rr_first_cycle", gcyc[0], 0);
         p = 0;
         for (int g = 0; g < 5; g++) begin
            w = rr_pick(4'hF, p);
            chk("rr_order", gidx[g], w);
            if (g > 0) chk("rr_space", gcyc[g] - gcyc[g-1], 3);
            p = (w + 1) % 4;
         end
      end
      repeat (4) step();
      chk("rr_idle", busy1, 0);

      // divide by zero
      run_op(2, 8'd55, 8'd0);
      chk("dz_q", q1, 8'd255);
      chk("dz_r", r1, 8'd55);
      chk("dz_flag", dz1, 1);

      // request raised during EXEC and withdrawn before RESP is never granted
      req            = 4'b0001;
      a_in[7:0]      = 8'd99;
      b_in[7:0]      = 8'd10;
      @(negedge clk);
      chk("cx_gnt0", gnt1, 4'b0001);
      step();
      req = 4'b0010;
      @(negedge clk);
      chk("cx_gnt_exec", gnt1, 0);
      step();
      req = 4'b0000;
      @(negedge clk);
      chk("cx_done", done1, 4'b0001);
      chk("cx_q", q1, 8'd9);
      repeat (3) begin
         step();
         @(negedge clk);
         chk("cx_no_gnt", gnt1, 0);
         chk("cx_idle", busy1, 0);
      end
      step();

      // boundary operands through requester 3
      bnd_a = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd1, 8'd254};
      bnd_b = '{8'd1, 8'd1, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255};
      for (int n = 0; n < 7; n++) run_op(3, bnd_a[n], bnd_b[n]);

      // random operands, requester 3 first, then any requester
      for (int n = 0; n < 1200; n++) begin
         k  = (n < 400) ? 3 : int'($urandom_range(0, 3));
         ta = 8'($urandom);
         tb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         run_op(k, ta, tb);
      end

      // slower divider: normal op, then reset two cycles after grant
      use3 = 1'b1;
      do_reset();
      run_op(1, 8'd100, 8'd7);
      run_op(2, 8'd77, 8'd0);
      run_op(1, 8'd100, 8'd7);
      chk("l3_q_before_abort", q3, 8'd14);
      req       = 4'b0010;
      a_in[15:8] = 8'd9;
      b_in[15:8] = 8'd2;
      k = 0;
      @(negedge clk);
      while (gnt3 == 0 && k < 20) begin
         k++;
         @(negedge clk);
      end
      chk("ab_gnt", gnt3, 4'b0010);
      step();
      req = '0;
      @(negedge clk);
      chk("ab_done_t1", done3, 0);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("ab_done_t2", done3, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("ab_busy", busy3, 0);
      chk("ab_q", q3, 0);
      chk("ab_dz", dz3, 0);
      chk("ab_done_t3", done3, 0);
      repeat (4) begin
         @(negedge clk);
         chk("ab_no_done", done3, 0);
      end
      step();
      req = 4'hF;
      @(negedge clk);
      chk("ab_ptr0", gnt3, 4'b0001);
      step();
      req = '0;
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
